// File: rtl/dma_flit_fetcher.sv
// DMA flit fetcher: reads one command's worth of flits from the PDU ring
// buffer and streams them out with sop/eop framing. A credit check on
// reads in flight plus FIFO occupancy keeps the skid FIFO from overflowing.
//
// state | meaning
// IDLE  | waiting for dma_start
// FETCH | issuing ring-buffer reads under credit control
// DRAIN | all reads issued, emptying the FIFO until eop is accepted
// ZERO  | zero-length command, fixed delay before dma_done
module dma_flit_fetcher #(
  parameter int PDU_DEPTH     = 512,
  parameter int PDU_AWIDTH    = $clog2(PDU_DEPTH),
  parameter int APP_IDX_WIDTH = 8,
  parameter int FIFO_DEPTH    = 8,
  parameter int RD_LATENCY    = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     dma_start,
  input  logic [PDU_AWIDTH-1:0]    dma_size,
  input  logic [PDU_AWIDTH-1:0]    dma_base_addr,
  input  logic [APP_IDX_WIDTH-1:0] dma_queue,
  output logic                     dma_done,
  output logic [PDU_AWIDTH-1:0]    rd_addr,
  output logic                     rd_en,
  input  logic                     rd_valid,
  input  logic [511:0]             rd_data,
  output logic [511:0]             out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_sop,
  output logic                     out_eop,
  output logic [APP_IDX_WIDTH-1:0] out_queue,
  output logic                     busy,
  output logic                     err_start_busy
);

  localparam int FAW = $clog2(FIFO_DEPTH);
  localparam logic [FAW+1:0] CREDIT_MAX = (FAW+2)'(FIFO_DEPTH);

  // The credit scheme only covers a ring buffer whose latency is shorter
  // than the FIFO can absorb; anything else is a parameterisation error.
  if (RD_LATENCY < 1 || RD_LATENCY >= FIFO_DEPTH || FIFO_DEPTH < 4) begin : g_bad_params
    $error("dma_flit_fetcher: unsupported RD_LATENCY/FIFO_DEPTH");
  end

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, ZERO} state_t;

  state_t                   state, state_nxt;
  logic [PDU_AWIDTH-1:0]    size_r, base_r;
  logic [APP_IDX_WIDTH-1:0] queue_r;
  logic [PDU_AWIDTH:0]      issued, sent;
  logic [FAW:0]             inflight, fifo_count;
  logic [FAW-1:0]           wr_ptr, rd_ptr;
  logic [511:0]             fifo_mem [FIFO_DEPTH];
  logic                     zero_tmr;

  logic                     issue, done_nxt, push, pop, fifo_empty, last, credit_ok, accept;
  logic [PDU_AWIDTH-1:0]    issue_addr;

  assign fifo_empty = (fifo_count == '0);
  assign push       = rd_valid && (inflight != '0);
  assign pop        = !fifo_empty && out_ready;
  assign last       = (sent == ({1'b0, size_r} - (PDU_AWIDTH+1)'(1)));
  assign credit_ok  = (((FAW+2)'(inflight) + (FAW+2)'(fifo_count)) < CREDIT_MAX);
  assign accept     = (state == IDLE) && dma_start;

  // Outputs are forced to zero while the FIFO is empty so reset leaves every output low.
  assign out_valid = !fifo_empty;
  assign out_data  = fifo_empty ? '0 : fifo_mem[rd_ptr];
  assign out_sop   = !fifo_empty && (sent == '0);
  assign out_eop   = !fifo_empty && last;
  assign out_queue = queue_r;
  assign busy      = (state != IDLE);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state, read issue decision and completion pulse.
  always_comb begin
    state_nxt  = state;
    issue      = 1'b0;
    issue_addr = '0;
    done_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (dma_start) begin
          if (dma_size != '0) begin
            // First read goes out straight from IDLE so rd_en lands one cycle after start.
            issue      = 1'b1;
            issue_addr = dma_base_addr;
            state_nxt  = FETCH;
          end else begin
            state_nxt = ZERO;
          end
        end
      end
      FETCH: begin
        if (issued == {1'b0, size_r}) begin
          state_nxt = DRAIN;
        end else if (credit_ok) begin
          issue      = 1'b1;
          issue_addr = base_r + issued[PDU_AWIDTH-1:0];
        end
      end
      DRAIN: begin
        if (pop && last) begin
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end
      end
      ZERO: begin
        if (zero_tmr == 1'b0) begin
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Command latch, progress counters, registered read port and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      size_r         <= '0;
      base_r         <= '0;
      queue_r        <= '0;
      issued         <= '0;
      sent           <= '0;
      inflight       <= '0;
      zero_tmr       <= 1'b0;
      rd_en          <= 1'b0;
      rd_addr        <= '0;
      dma_done       <= 1'b0;
      err_start_busy <= 1'b0;
    end else begin
      rd_en    <= issue;
      dma_done <= done_nxt;
      if (issue) rd_addr <= issue_addr;
      if (dma_start && state != IDLE) err_start_busy <= 1'b1;

      if (accept) begin
        size_r   <= dma_size;
        base_r   <= dma_base_addr;
        queue_r  <= dma_queue;
        zero_tmr <= 1'b1;
        issued   <= issue ? (PDU_AWIDTH+1)'(1) : '0;
        sent     <= '0;
      end else begin
        if (issue) issued <= issued + (PDU_AWIDTH+1)'(1);
        if (pop)   sent   <= sent + (PDU_AWIDTH+1)'(1);
        if (state == ZERO && zero_tmr != 1'b0) zero_tmr <= zero_tmr - 1'b1;
      end

      case ({issue, push})
        2'b10:   inflight <= inflight + (FAW+1)'(1);
        2'b01:   inflight <= inflight - (FAW+1)'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + FAW'(1);
      if (pop)  rd_ptr <= rd_ptr + FAW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + (FAW+1)'(1);
        2'b01:   fifo_count <= fifo_count - (FAW+1)'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // FIFO storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= rd_data;
  end

endmodule

// File: tb/tb_dma_flit_fetcher.sv
// Scoreboard bench for dma_flit_fetcher with a 2-cycle ring-buffer model.
module tb_dma_flit_fetcher;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         dma_start = 1'b0;
  logic [8:0]   dma_size = '0;
  logic [8:0]   dma_base_addr = '0;
  logic [7:0]   dma_queue = '0;
  logic         dma_done;
  logic [8:0]   rd_addr;
  logic         rd_en;
  logic         rd_valid;
  logic [511:0] rd_data;
  logic [511:0] out_data;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic         out_sop, out_eop;
  logic [7:0]   out_queue;
  logic         busy, err_start_busy;

  dma_flit_fetcher dut (
    .clk(clk), .rst_n(rst_n), .dma_start(dma_start), .dma_size(dma_size),
    .dma_base_addr(dma_base_addr), .dma_queue(dma_queue), .dma_done(dma_done),
    .rd_addr(rd_addr), .rd_en(rd_en), .rd_valid(rd_valid), .rd_data(rd_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_sop(out_sop), .out_eop(out_eop), .out_queue(out_queue),
    .busy(busy), .err_start_busy(err_start_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [511:0] mem_word(input logic [8:0] a);
    logic [31:0] w;
    w = 32'hABCD0000 + 32'(a);
    return {16{w}};
  endfunction

  // Ring buffer model: fixed 2-cycle read latency, plus a stray-valid injector.
  logic       v1 = 1'b0, v2 = 1'b0, inject = 1'b0;
  logic [8:0] a1 = '0, a2 = '0;
  always @(posedge clk) begin
    v1 <= rd_en;  a1 <= rd_addr;
    v2 <= v1;     a2 <= a1;
  end
  assign rd_valid = v2 | inject;
  assign rd_data  = inject ? {16{32'hDEADBEEF}} : mem_word(a2);

  int total = 0, bad = 0;

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  typedef struct packed {
    logic [511:0] d;
    logic         sop;
    logic         eop;
    logic [7:0]   q;
  } exp_t;

  exp_t       sb[$];
  logic [8:0] addr_q[$];
  int rd_total = 0, pop_total = 0, done_cnt = 0, done_cyc = -1;
  int first_rd = -1, first_out = -1, sop_cnt = 0, eop_cnt = 0;
  logic         hold_v = 1'b0;
  logic [511:0] hold_d = '0;

  // Output monitor: scoreboard pops, read-address order, credit bound, payload hold.
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_v = 1'b0;
    end else begin
      if (rd_en) begin
        rd_total++;
        if (first_rd < 0) first_rd = cyc;
        chk("credit", 512'(rd_total - pop_total <= 8), 512'(1));
        if (addr_q.size() == 0) chk("rd_extra", 512'(rd_addr), 512'h1FF_FFFF);
        else chk("rd_addr", 512'(rd_addr), 512'(addr_q.pop_front()));
      end
      if (hold_v) begin
        chk("hold_valid", 512'(out_valid), 512'(1));
        chk("hold_data", out_data, hold_d);
      end
      hold_v = out_valid && !out_ready;
      hold_d = out_data;
      if (out_valid && first_out < 0) first_out = cyc;
      if (out_valid && out_ready) begin
        exp_t e;
        pop_total++;
        if (out_sop) sop_cnt++;
        if (out_eop) eop_cnt++;
        if (sb.size() == 0) begin
          chk("out_extra", 512'(out_valid), 512'(0));
        end else begin
          e = sb.pop_front();
          chk("out_data", out_data, e.d);
          chk("out_sop", 512'(out_sop), 512'(e.sop));
          chk("out_eop", 512'(out_eop), 512'(e.eop));
          chk("out_queue", 512'(out_queue), 512'(e.q));
        end
      end
      if (dma_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  // Drive one command, push its expectations and wait (bounded) for dma_done.
  // exp_lat < 0 skips the exact completion-time check; busy_at >= 0 fires a
  // second, illegal start that many cycles after the first.
  task automatic run_cmd(input logic [8:0] base, input int size, input logic [7:0] q,
                         input bit bp, input int exp_lat, input int busy_at);
    int t0, k;
    exp_t e;
    for (int i = 0; i < size; i++) begin
      e.d = mem_word(base + 9'(i));
      e.sop = (i == 0);
      e.eop = (i == size - 1);
      e.q = q;
      sb.push_back(e);
      addr_q.push_back(base + 9'(i));
    end
    done_cnt = 0; done_cyc = -1; first_rd = -1; first_out = -1; sop_cnt = 0; eop_cnt = 0;
    @(posedge clk); #1;
    dma_start = 1'b1; dma_base_addr = base; dma_size = 9'(size); dma_queue = q;
    out_ready = bp ? ($urandom_range(0, 9) < 3) : 1'b1;
    t0 = cyc;
    k = 0;
    while (done_cnt == 0 && k < 600) begin
      @(posedge clk); #1;
      k++;
      dma_start = (busy_at >= 0 && k == busy_at);
      if (dma_start) begin
        dma_base_addr = 9'd300; dma_size = 9'd3; dma_queue = 8'hEE;
      end
      out_ready = bp ? ($urandom_range(0, 9) < 3) : 1'b1;
    end
    dma_start = 1'b0;
    out_ready = 1'b1;
    chk("done_cnt", 512'(done_cnt), 512'(1));
    if (exp_lat >= 0) chk("done_cycle", 512'(done_cyc - t0), 512'(exp_lat));
    chk("sb_empty", 512'(sb.size()), 512'(0));
    chk("addr_empty", 512'(addr_q.size()), 512'(0));
    chk("sop_cnt", 512'(sop_cnt), 512'(size > 0 ? 1 : 0));
    chk("eop_cnt", 512'(eop_cnt), 512'(size > 0 ? 1 : 0));
    if (size > 0 && !bp) begin
      chk("first_rd", 512'(first_rd - t0), 512'(1));
      chk("first_out", 512'(first_out - t0), 512'(4));
    end
    if (size == 0) begin
      chk("zero_no_rd", 512'(first_rd), 512'(-1));
      chk("zero_no_out", 512'(first_out), 512'(-1));
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 512'(busy), 512'(0));
    chk("rst_valid", 512'(out_valid), 512'(0));
    chk("rst_rd_en", 512'(rd_en), 512'(0));
    chk("rst_done", 512'(dma_done), 512'(0));
    chk("rst_err", 512'(err_start_busy), 512'(0));
    @(posedge clk); #1 rst_n = 1'b1;

    run_cmd(9'd10, 4, 8'd3, 1'b0, 8, -1);     // basic
    run_cmd(9'd510, 4, 8'd7, 1'b0, 8, -1);    // address wrap
    run_cmd(9'd40, 20, 8'd9, 1'b1, -1, -1);   // random backpressure
    run_cmd(9'd77, 0, 8'd1, 1'b0, 3, -1);     // zero size
    chk("err_before", 512'(err_start_busy), 512'(0));
    run_cmd(9'd200, 8, 8'd4, 1'b0, 12, 2);    // illegal start during FETCH
    chk("err_set", 512'(err_start_busy), 512'(1));
    run_cmd(9'd5, 1, 8'd2, 1'b0, 5, -1);      // single flit, err stays sticky
    chk("err_sticky", 512'(err_start_busy), 512'(1));

    // Mid-command reset with three flits parked in the FIFO.
    addr_q.push_back(9'd100); addr_q.push_back(9'd101); addr_q.push_back(9'd102);
    @(posedge clk); #1;
    out_ready = 1'b0;
    dma_start = 1'b1; dma_base_addr = 9'd100; dma_size = 9'd3; dma_queue = 8'd6;
    @(posedge clk); #1 dma_start = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    chk("pre_rst_valid", 512'(out_valid), 512'(1));
    chk("pre_rst_busy", 512'(busy), 512'(1));
    @(posedge clk); #1 rst_n = 1'b0;
    #1;
    chk("mid_busy", 512'(busy), 512'(0));
    chk("mid_valid", 512'(out_valid), 512'(0));
    chk("mid_sop", 512'(out_sop), 512'(0));
    chk("mid_queue", 512'(out_queue), 512'(0));
    chk("mid_data", out_data, 512'(0));
    chk("mid_err", 512'(err_start_busy), 512'(0));
    chk("mid_rd_en", 512'(rd_en), 512'(0));
    sb.delete(); addr_q.delete();
    rd_total = 0; pop_total = 0;
    @(posedge clk); #1 rst_n = 1'b1; out_ready = 1'b1;
    inject = 1'b1;
    @(posedge clk); #1 inject = 1'b0;
    @(negedge clk);
    chk("stray_valid", 512'(out_valid), 512'(0));
    @(negedge clk);
    chk("stray_valid2", 512'(out_valid), 512'(0));
    run_cmd(9'd0, 2, 8'd5, 1'b0, 6, -1);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
